// File: rtl/seq_divider.sv
// Unsigned sequential divider by repeated subtraction. The dividend and the divisor
// arrive on one shared bus on consecutive cycles, and the result is held under done.
module seq_divider #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_CALC,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             dbz_q, dbz_d;

    // NOTE: state updates use non-blocking assignments so that every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            dbz_q   <= dbz_d;
        end
    end

    // NOTE: every next-state signal is defaulted to its current value first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        dbz_d   = dbz_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_LOAD_A;
            end
            S_LOAD_A: begin
                rem_d   = data_in;
                state_d = S_LOAD_B;
            end
            S_LOAD_B: begin
                dvs_d   = data_in;
                quo_d   = '0;
                dbz_d   = 1'b0;
                state_d = S_CALC;
            end
            S_CALC: begin
                if (dvs_q == '0) begin
                    dbz_d   = 1'b1;
                    quo_d   = '1;
                    state_d = S_DONE;
                end else if (rem_q >= dvs_q) begin
                    // The >= guard keeps the subtraction from underflowing.
                    rem_d = rem_q - dvs_q;
                    quo_d = quo_q + WIDTH'(1);
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    dbz_d   = 1'b0;
                    state_d = S_LOAD_A;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
    assign done        = (state_q == S_DONE);
    assign busy        = (state_q == S_LOAD_A) || (state_q == S_LOAD_B) || (state_q == S_CALC);

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider. It queues the expected results and the completion cycle
// when each operation starts, then pops and compares them on every rising edge of done.
module tb_seq_divider;

    localparam int unsigned W = 16;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           due;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] data_in;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         done;
    logic         div_by_zero;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    logic done_d = 1'b0;
    exp_t sb[$];

    seq_divider #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .data_in    (data_in),
        .quotient   (quotient),
        .remainder  (remainder),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Compare the result on each rising edge of done.
    always @(negedge clk) begin
        if (rst_n && done && !done_d) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("quotient", 32'(quotient), 32'(e.q));
                check("remainder", 32'(remainder), 32'(e.r));
                check("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
                check("latency", 32'(cyc), 32'(e.due));
                check("busy_in_done", 32'(busy), 32'd0);
            end
        end
        done_d <= done;
    end

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int now);
        exp_t e;
        if (b == '0) begin
            e.q   = '1;
            e.r   = a;
            e.dbz = 1'b1;
            e.due = now + 4;
        end else begin
            e.q   = a / b;
            e.r   = a % b;
            e.dbz = 1'b0;
            e.due = now + 4 + int'(a / b);
        end
        return e;
    endfunction

    // Called at a negedge while the DUT is in IDLE or DONE.
    task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b);
        start = 1'b1;
        sb.push_back(model(a, b, cyc));
        @(negedge clk);
        start   = 1'b0;
        data_in = a;
        @(negedge clk);
        data_in = b;
        @(negedge clk);
        data_in = W'($urandom);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        data_in = '0;
        repeat (3) @(negedge clk);
        check("rst_quotient", 32'(quotient), 32'd0);
        check("rst_remainder", 32'(remainder), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_dbz", 32'(div_by_zero), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_div(16'd17, 16'd5);
        drain(50);
        repeat (3) @(negedge clk);
        check("done_hold", 32'(done), 32'd1);
        check("quotient_hold", 32'(quotient), 32'd3);

        do_div(16'd5, 16'd17);
        drain(50);
        do_div(16'd0, 16'd9);
        drain(50);
        do_div(16'd100, 16'd0);
        drain(50);

        // Worst case, with start pulses during CALC that must be ignored.
        do_div(16'hFFFF, 16'd1);
        check("busy_calc", 32'(busy), 32'd1);
        for (int i = 0; i < 6; i++) begin
            repeat (7) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        drain(70000);

        // Asynchronous reset in the middle of a calculation.
        do_div(16'd60000, 16'd3);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_quotient", 32'(quotient), 32'd0);
        check("arst_remainder", 32'(remainder), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_dbz", 32'(div_by_zero), 32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_div(16'd40, 16'd7);
        drain(50);

        // Start held high: 9/3 then 10/4 back to back.
        start = 1'b1;
        sb.push_back(model(16'd9, 16'd3, cyc));
        @(negedge clk);
        data_in = 16'd9;
        @(negedge clk);
        data_in = 16'd3;
        repeat (5) @(negedge clk);
        check("b2b_done_first", 32'(done), 32'd1);
        sb.push_back(model(16'd10, 16'd4, cyc));
        @(negedge clk);
        check("b2b_gap_load_a", 32'(done), 32'd0);
        data_in = 16'd10;
        @(negedge clk);
        check("b2b_gap_load_b", 32'(done), 32'd0);
        data_in = 16'd4;
        @(negedge clk);
        check("b2b_gap_calc", 32'(done), 32'd0);
        start = 1'b0;
        drain(50);

        for (int i = 0; i < 4; i++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            a = W'($urandom_range(0, 3000));
            b = W'($urandom_range(0, 40));
            do_div(a, b);
            drain(4000);
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
